// File: rtl/alu_pkg.sv
// Shared types for the 8-bit ALU sequencer: opcodes, sequencer states, instruction fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int INSTR_W  = 9;
    localparam int DATA_W   = 8;
    localparam int OP_MSB   = 8;
    localparam int OP_LSB   = 6;
    localparam int RA_MSB   = 5;
    localparam int RA_LSB   = 3;
    localparam int RB_MSB   = 2;
    localparam int RB_LSB   = 0;
    localparam int BR_OFF_W = 6;

    typedef enum logic [2:0] {
        OP_LDR   = 3'b000,
        OP_STR   = 3'b001,
        OP_MOV   = 3'b010,
        OP_XOR   = 3'b011,
        OP_AND   = 3'b100,
        OP_SHIFT = 3'b101,
        OP_CMP   = 3'b110,
        OP_BR    = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_e;

    // Decoded view of the instruction register.
    typedef struct packed {
        opcode_e               op;
        logic [2:0]            ra;
        logic [2:0]            rb;
        logic [1:0]            immed;
        logic                  direct;
        logic [BR_OFF_W-1:0]   br_off;
        logic                  wr_alu;     // writes ALU result to R[ra]
        logic                  upd_carry;  // latches alu_sc_o
        logic                  is_cmp;
        logic                  is_br;
        logic                  is_mem;     // needs a MEM phase
        logic                  is_store;
    } dec_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: ir -> field extraction and control strobes.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows ir every cycle.
// Ports: ir (9-bit instruction register) in, dec (decoded fields/strobes) out.
module alu_seq_decode
    import alu_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output dec_t               dec
);

    always_comb begin
        dec        = '0;
        dec.op     = opcode_e'(ir[OP_MSB:OP_LSB]);
        dec.ra     = ir[RA_MSB:RA_LSB];
        dec.rb     = ir[RB_MSB:RB_LSB];
        dec.immed  = ir[1:0];
        dec.direct = ir[2];
        dec.br_off = ir[BR_OFF_W-1:0];
        case (ir[OP_MSB:OP_LSB])
            OP_MOV, OP_XOR, OP_AND: dec.wr_alu = 1'b1;
            OP_SHIFT: begin
                dec.wr_alu    = 1'b1;
                dec.upd_carry = 1'b1;
            end
            OP_CMP:  dec.is_cmp = 1'b1;
            OP_BR:   dec.is_br  = 1'b1;
            OP_LDR:  dec.is_mem = 1'b1;
            OP_STR: begin
                dec.is_mem   = 1'b1;
                dec.is_store = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU control sequencer: fetch 9-bit instruction, decode, drive ALU, sequence data memory and writeback.
// Latency: 2 cycles per ALU/CMP/BR op, 3 per LDR/STR with zero-wait memories.
// Backpressure: imem_req / dmem_req are held until the matching _vld; stray _vld outside FETCH/MEM is ignored.
// Ports: clk/rst_n; start/done; imem_req/addr/vld/data; rf_ra/rb/da/db/we/wa/wd;
//        alu_cmd/immed/direct/inA/inB/sc_i and alu_rslt/sc_o/pari/zero/br;
//        dmem_req/we/addr/wdata/rdata/vld; registered zero_f/pari_f.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int              PC_W   = 10,
    parameter int              RF_AW  = 3,
    parameter logic [PC_W-1:0] END_PC = '1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                done,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_vld,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [RF_AW-1:0]    rf_ra,
    output logic [RF_AW-1:0]    rf_rb,
    input  logic [DATA_W-1:0]   rf_da,
    input  logic [DATA_W-1:0]   rf_db,
    output logic                rf_we,
    output logic [RF_AW-1:0]    rf_wa,
    output logic [DATA_W-1:0]   rf_wd,
    output logic [2:0]          alu_cmd,
    output logic [1:0]          alu_immed,
    output logic                alu_direct,
    output logic [DATA_W-1:0]   alu_inA,
    output logic [DATA_W-1:0]   alu_inB,
    output logic                alu_sc_i,
    input  logic [DATA_W-1:0]   alu_rslt,
    input  logic                alu_sc_o,
    input  logic                alu_pari,
    input  logic                alu_zero,
    input  logic                alu_br,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic [DATA_W-1:0]   dmem_rdata,
    input  logic                dmem_vld,
    output logic                zero_f,
    output logic                pari_f
);

    seq_state_e          state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                carry_q, carry_d;
    logic                br_q, br_d;
    logic                zero_f_q, zero_f_d;
    logic                pari_f_q, pari_f_d;

    dec_t                dec;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     pc_br;

    alu_seq_decode u_decode (
        .ir  (ir_q),
        .dec (dec)
    );

    // Both targets wrap naturally modulo 2^PC_W.
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_br  = pc_q + {{(PC_W-BR_OFF_W){dec.br_off[BR_OFF_W-1]}}, dec.br_off};

    assign imem_addr  = pc_q;
    assign rf_ra      = RF_AW'(dec.ra);
    assign rf_rb      = RF_AW'(dec.rb);
    assign dmem_addr  = rf_da;
    assign dmem_wdata = rf_db;
    assign zero_f     = zero_f_q;
    assign pari_f     = pari_f_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        carry_d    = carry_q;
        br_d       = br_q;
        zero_f_d   = zero_f_q;
        pari_f_d   = pari_f_q;
        done       = 1'b0;
        imem_req   = 1'b0;
        rf_we      = 1'b0;
        rf_wa      = '0;
        rf_wd      = '0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_cmd    = '0;
        alu_immed  = '0;
        alu_direct = 1'b0;
        alu_inA    = '0;
        alu_inB    = '0;
        alu_sc_i   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end

            ST_FETCH: begin
                // Halt address is checked before any request goes out.
                if (pc_q == END_PC) begin
                    state_d = ST_HALT;
                end else begin
                    imem_req = 1'b1;
                    if (imem_vld) begin
                        ir_d    = imem_data;
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                alu_cmd    = dec.op;
                alu_immed  = dec.immed;
                alu_direct = dec.direct;
                alu_inA    = rf_da;
                alu_inB    = rf_db;
                alu_sc_i   = carry_q;
                state_d    = ST_FETCH;
                pc_d       = pc_inc;
                if (dec.wr_alu) begin
                    rf_we    = 1'b1;
                    rf_wa    = RF_AW'(dec.ra);
                    rf_wd    = alu_rslt;
                    zero_f_d = alu_zero;
                    pari_f_d = alu_pari;
                end
                if (dec.upd_carry) carry_d = alu_sc_o;
                if (dec.is_cmp)    br_d    = alu_br;
                if (dec.is_br && br_q) pc_d = pc_br;
                // Loads/stores advance pc only once the access completes.
                if (dec.is_mem) begin
                    state_d = ST_MEM;
                    pc_d    = pc_q;
                end
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec.is_store;
                if (dmem_vld) begin
                    if (!dec.is_store) begin
                        rf_we = 1'b1;
                        rf_wa = RF_AW'(dec.rb);
                        rf_wd = dmem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end

            ST_HALT: begin
                done = 1'b1;
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            carry_q  <= 1'b0;
            br_q     <= 1'b0;
            zero_f_q <= 1'b0;
            pari_f_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            carry_q  <= carry_d;
            br_q     <= br_d;
            zero_f_q <= zero_f_d;
            pari_f_q <= pari_f_d;
        end
    end

endmodule
